// File: rtl/load_store_queue_if.sv
// Data-cache request/response port of the load/store queue.
// master: queue side (drives the request), slave: memory side (returns completion).
interface load_store_queue_if;
   logic        mem_valid;
   logic        mem_wr;
   logic [2:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_wr, mem_size, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_wr, mem_size, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue: circular FIFO of memory ops between decode and
// the data-cache port. Operands are snooped from the CDB channels and from the
// queue's own registered result bus; one op is issued at a time, in order.
//
// state | meaning
// IDLE  | no request outstanding; waiting for the head entry to become issuable
// ISSUE | request for the head entry on the memory port, waiting for mem_ready
// DRAIN | flushed while a request was outstanding; wait for it, drop the result
module load_store_queue #(
   parameter int          LSQ_SIZE_BIT  = 3,
   parameter int          ROB_WIDTH_BIT = 4,
   parameter int          NUM_CDB       = 2,
   parameter logic [31:0] IO_BASE       = 32'h0003_0000
) (
   input  logic                             clk_in,
   input  logic                             rst_n_in,
   input  logic                             rdy_in,
   input  logic                             flush_in,
   input  logic                             inst_valid,
   input  logic [3:0]                       inst_type,
   input  logic [31:0]                      inst_r1,
   input  logic [31:0]                      inst_r2,
   input  logic [ROB_WIDTH_BIT-1:0]         inst_dep1,
   input  logic [ROB_WIDTH_BIT-1:0]         inst_dep2,
   input  logic                             inst_has_dep1,
   input  logic                             inst_has_dep2,
   input  logic [11:0]                      inst_offset,
   input  logic [ROB_WIDTH_BIT-1:0]         inst_rob_id,
   output logic                             full,
   input  logic [NUM_CDB-1:0]               cdb_valid,
   input  logic [NUM_CDB*ROB_WIDTH_BIT-1:0] cdb_rob_id,
   input  logic [NUM_CDB*32-1:0]            cdb_value,
   input  logic [ROB_WIDTH_BIT-1:0]         rob_head_id,
   load_store_queue_if.master               mem,
   output logic                             out_valid,
   output logic [ROB_WIDTH_BIT-1:0]         out_rob_id,
   output logic [31:0]                      out_value
);

   localparam int SIZE = 1 << LSQ_SIZE_BIT;
   localparam logic [LSQ_SIZE_BIT:0]   CNT_FULL = (LSQ_SIZE_BIT+1)'(SIZE);
   localparam logic [LSQ_SIZE_BIT:0]   CNT_ONE  = (LSQ_SIZE_BIT+1)'(1);
   localparam logic [LSQ_SIZE_BIT-1:0] PTR_ONE  = LSQ_SIZE_BIT'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t state_q, state_d;

   logic [SIZE-1:0]          e_busy;
   logic [SIZE-1:0]          e_has_dep1;
   logic [SIZE-1:0]          e_has_dep2;
   logic [3:0]               e_type   [SIZE];
   logic [31:0]              e_r1     [SIZE];
   logic [31:0]              e_r2     [SIZE];
   logic [ROB_WIDTH_BIT-1:0] e_dep1   [SIZE];
   logic [ROB_WIDTH_BIT-1:0] e_dep2   [SIZE];
   logic [11:0]              e_offset [SIZE];
   logic [ROB_WIDTH_BIT-1:0] e_rob    [SIZE];

   logic [LSQ_SIZE_BIT-1:0] head, tail;
   logic [LSQ_SIZE_BIT:0]   count;

   logic                     req_wr;
   logic [2:0]               req_size;
   logic [31:0]              req_addr;
   logic [31:0]              req_wdata;
   logic [ROB_WIDTH_BIT-1:0] req_rob;

   logic [SIZE-1:0] w1_hit, w2_hit;
   logic [31:0]     w1_val [SIZE];
   logic [31:0]     w2_val [SIZE];
   logic            p1_hit, p2_hit;
   logic [31:0]     p1_val, p2_val;

   logic [31:0] head_addr;
   logic        head_is_store, head_mmio, head_ready;
   logic        push, pop, start_issue;

   // Broadcast match for one tag: lowest CDB index wins, own result bus last.
   function automatic logic [32:0] snoop(input logic [ROB_WIDTH_BIT-1:0] tag);
      logic [32:0] r;
      r = '0;
      if (out_valid && out_rob_id == tag) r = {1'b1, out_value};
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
         if (cdb_valid[c] && cdb_rob_id[c*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == tag)
            r = {1'b1, cdb_value[c*32 +: 32]};
      end
      return r;
   endfunction

   // Operand matches for stored entries and for the op being pushed.
   always_comb begin
      w1_hit = '0;
      w2_hit = '0;
      for (int i = 0; i < SIZE; i++) begin
         {w1_hit[i], w1_val[i]} = snoop(e_dep1[i]);
         {w2_hit[i], w2_val[i]} = snoop(e_dep2[i]);
      end
      {p1_hit, p1_val} = snoop(inst_dep1);
      {p2_hit, p2_val} = snoop(inst_dep2);
   end

   // Head issue check; MMIO loads and stores must wait for the ROB head.
   always_comb begin
      head_addr     = e_r1[head] + {{20{e_offset[head][11]}}, e_offset[head]};
      head_is_store = e_type[head][3];
      head_mmio     = !head_is_store && (head_addr >= IO_BASE);
      head_ready    = e_busy[head] && !e_has_dep1[head] && !e_has_dep2[head] &&
                      ((!head_is_store && !head_mmio) || (e_rob[head] == rob_head_id));
   end

   assign full = (count == CNT_FULL) || (state_q == DRAIN);
   assign push = inst_valid && !full && !flush_in;
   assign pop  = (state_q == ISSUE) && mem.mem_ready && !flush_in;

   // Next-state logic; a flush cancels a pending IDLE->ISSUE decision.
   always_comb begin
      state_d     = state_q;
      start_issue = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (head_ready && !flush_in) begin
               state_d     = ISSUE;
               start_issue = 1'b1;
            end
         end
         ISSUE: begin
            if (mem.mem_ready)  state_d = IDLE;
            else if (flush_in)  state_d = DRAIN;
         end
         DRAIN: begin
            if (mem.mem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; a low rdy_in freezes the FSM.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   state_q <= IDLE;
      else if (rdy_in) state_q <= state_d;
   end

   // Queue storage, pointers, request latch and result register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         e_busy     <= '0;
         e_has_dep1 <= '0;
         e_has_dep2 <= '0;
         for (int i = 0; i < SIZE; i++) begin
            e_type[i]   <= '0;
            e_r1[i]     <= '0;
            e_r2[i]     <= '0;
            e_dep1[i]   <= '0;
            e_dep2[i]   <= '0;
            e_offset[i] <= '0;
            e_rob[i]    <= '0;
         end
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         req_wr     <= 1'b0;
         req_size   <= '0;
         req_addr   <= '0;
         req_wdata  <= '0;
         req_rob    <= '0;
         out_valid  <= 1'b0;
         out_rob_id <= '0;
         out_value  <= '0;
      end else if (rdy_in) begin
         out_valid <= 1'b0;

         for (int i = 0; i < SIZE; i++) begin
            if (e_busy[i] && e_has_dep1[i] && w1_hit[i]) begin
               e_r1[i]       <= w1_val[i];
               e_has_dep1[i] <= 1'b0;
            end
            if (e_busy[i] && e_has_dep2[i] && w2_hit[i]) begin
               e_r2[i]       <= w2_val[i];
               e_has_dep2[i] <= 1'b0;
            end
         end

         if (start_issue) begin
            req_wr    <= head_is_store;
            req_size  <= e_type[head][2:0];
            req_addr  <= head_addr;
            req_wdata <= e_r2[head];
            req_rob   <= e_rob[head];
         end

         if (flush_in) begin
            e_busy <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               e_busy[tail]     <= 1'b1;
               e_type[tail]     <= inst_type;
               e_r1[tail]       <= (inst_has_dep1 && p1_hit) ? p1_val : inst_r1;
               e_r2[tail]       <= (inst_has_dep2 && p2_hit) ? p2_val : inst_r2;
               e_has_dep1[tail] <= inst_has_dep1 && !p1_hit;
               e_has_dep2[tail] <= inst_has_dep2 && !p2_hit;
               e_dep1[tail]     <= inst_dep1;
               e_dep2[tail]     <= inst_dep2;
               e_offset[tail]   <= inst_offset;
               e_rob[tail]      <= inst_rob_id;
               tail             <= tail + PTR_ONE;
            end
            if (pop) begin
               e_busy[head] <= 1'b0;
               head         <= head + PTR_ONE;
               out_valid    <= 1'b1;
               out_rob_id   <= req_rob;
               out_value    <= req_wr ? 32'h0 : mem.mem_rdata;
            end
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
         end
      end
   end

   assign mem.mem_valid = (state_q != IDLE);
   assign mem.mem_wr    = req_wr;
   assign mem.mem_size  = req_size;
   assign mem.mem_addr  = req_addr;
   assign mem.mem_wdata = req_wdata;

endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
- Parametrised successor to the in-order load/store buffer: a circular FIFO of memory ops between the decoder and the data-cache port.
- Captures operands from N common-data-bus channels plus its own result bus.
- Issues one memory op at a time, strictly in program order.
- Adds over the previous generation: configurable depth/CDB count, pipeline flush with in-flight drain, MMIO loads held until non-speculative, registered result.

Parameters:
- LSQ_SIZE_BIT, 3, log2 of entry count (SIZE = 2**LSQ_SIZE_BIT).
- ROB_WIDTH_BIT, 4, ROB tag width.
- NUM_CDB, 2, external broadcast channels.
- IO_BASE, 32'h0003_0000, loads with addr >= IO_BASE are MMIO.

Ports:
- clk_in  in  1  clock; all state on rising edge.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global stall; low freezes all state; outputs hold.
- flush_in  in  1  misprediction flush, one-cycle pulse.
- inst_valid  in  1  push request; ignored when full=1.
- inst_type  in  4  [3] store, [2] unsigned load, [1:0] size (0 B, 1 H, 2 W).
- inst_r1, inst_r2  in  32  base / store data.
- inst_dep1, inst_dep2  in  ROB_WIDTH_BIT  producer tags.
- inst_has_dep1, inst_has_dep2  in  1  operand pending.
- inst_offset  in  12  signed immediate.
- inst_rob_id  in  ROB_WIDTH_BIT  tag of this op.
- full  out  1  count==SIZE, or state==DRAIN.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_rob_id  in  NUM_CDB*ROB_WIDTH_BIT  packed tags, channel 0 in LSBs.
- cdb_value  in  NUM_CDB*32  packed values.
- rob_head_id  in  ROB_WIDTH_BIT  tag at ROB head.
- mem_valid  out  1  request; held until mem_ready.
- mem_wr  out  1  1=store.
- mem_size  out  3  inst_type[2:0] of issued op.
- mem_addr  out  32  r1 + sign-extended offset.
- mem_wdata  out  32  r2.
- mem_ready  in  1  one-cycle completion pulse.
- mem_rdata  in  32  load data (already extended).
- out_valid  out  1  result broadcast, registered.
- out_rob_id  out  ROB_WIDTH_BIT  tag of completed op.
- out_value  out  32  load data; 0 for stores.

Behaviour:
- Reset (rst_n_in=0, async): head=tail=count=0, all busy=0, state=IDLE; mem_valid=0, out_valid=0, out_rob_id=0, out_value=0, full=0.
- Push: inst_valid && !full writes entry[tail], tail++ (wraps mod SIZE), count++.
- Same-cycle bypass at push: a pending operand whose tag matches a valid CDB channel or out_valid/out_rob_id is captured; has_dep stored 0.
- Wakeup: each cycle every busy entry with a pending dep matching a valid broadcast captures the value and clears has_dep. Lowest CDB index wins; own out bus has lowest priority.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE when entry[head] busy, no pending deps, and either:
  - load with addr < IO_BASE, or
  - (store or MMIO load) with rob_id == rob_head_id.
  - mem_valid rises the next cycle; minimum push-to-mem_valid latency is 2 cycles.
- ISSUE: mem_* driven from entry[head], stable until mem_ready. On mem_ready:
  - out_valid=1 next cycle with out_rob_id and out_value (mem_rdata for loads, 0 for stores);
  - busy[head]=0, head++, count--, state -> IDLE.
  - No back-to-back issue: at least one IDLE cycle between requests.
- out_valid is high for exactly one cycle per completed op.
- Simultaneous push and pop: count unchanged. If count==SIZE, full=1 and no push that cycle.
- flush_in, no op in flight: next cycle all busy=0, head=tail=count=0, state=IDLE.
- flush_in while in ISSUE: clear all entries as above; state -> DRAIN; mem_* held.
  - On mem_ready: store write completes, result discarded; load result discarded. out_valid stays 0; state -> IDLE.
- flush_in concurrent with inst_valid: push dropped.
- flush_in concurrent with mem_ready: result discarded, state -> IDLE.
- rdy_in=0 overrides everything except async reset.
- Address: 32-bit add, wraps modulo 2^32. Misalignment is not checked.

Test Plan:
- Push LW r1=0x100, off=-4, no deps, then mem_ready with rdata 0xDEADBEEF -> mem_addr=0xFC, mem_size=2, mem_wr=0; next cycle out_valid=1, out_value=0xDEADBEEF.
- Push SW tag 5 with rob_head_id=3 -> no mem_valid. Set rob_head_id=5 -> mem_valid after 1 cycle, mem_wr=1, mem_wdata=r2; after mem_ready, out_value=0.
- Push LB with has_dep1 tag 7, then cdb_valid[1]=1 with tag 7, value 0x2000 -> issues with mem_addr=0x2000+off. Repeat with the broadcast in the push cycle -> identical result.
- Fill SIZE=8 entries with no deps -> full=1, 9th inst_valid ignored; after one completion, full=0 and count=7.
- Load in flight, flush_in pulse, mem_ready 3 cycles later -> full=1 during DRAIN, no out_valid, count=0, state=IDLE afterwards.
- Load addr 0x30004 with tag≠rob_head_id -> no issue until tags match. Deassert rst_n_in mid-ISSUE -> mem_valid=0 immediately.
